// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input (valid/ready) plus the instruction-memory
// write port driven by the boot loader.
//   slave  : the loader side (consumes bytes, drives the imem write port)
//   master : the stream source / memory side
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer.
// Parses a framed byte stream:
//   MAGIC, cnt_lo, cnt_hi, 4*N payload bytes (LSB first), [checksum]
// Each assembled 32-bit word is written with a single-cycle wr_en pulse, and
// the core is held in reset (cpu_rst_n low) while a frame is being loaded.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing 8-bit payload
// checksum byte that decides between DONE and ERR.
module imem_loader #(
    parameter int unsigned BASE_WORD = 0,
    parameter int unsigned DEPTH     = 128,
    parameter logic [7:0]  MAGIC     = 8'hA5
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.slave  bus,
    output logic          cpu_rst_n,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_LO,
        S_CNT_HI,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_AFTER_LAST = S_CSUM;
`else
    localparam state_t S_AFTER_LAST = S_DONE;
`endif

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);
    localparam logic [31:0] BASE_W  = 32'(BASE_WORD);

    state_t      state_q, state_d;
    logic [15:0] cnt_q,   cnt_d;    // words still to write (low byte staged in CNT_LO)
    logic [1:0]  idx_q,   idx_d;    // byte position within the current word
    logic [23:0] asm_q,   asm_d;    // lower three bytes of the word being assembled
    logic [31:0] addr_q,  addr_d;
    logic [31:0] data_q,  data_d;   // only updated when a word is complete
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q,  csum_d;
`endif

    logic        xfer;
    logic [15:0] n_full;

    assign xfer   = bus.in_valid & bus.in_ready;
    assign n_full = {bus.in_data, cnt_q[7:0]};

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            asm_q   <= '0;
            addr_q  <= BASE_W;
            data_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // Frame parser: next state and next datapath values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        addr_d  = addr_q;
        data_d  = data_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                // Anything other than MAGIC is consumed and dropped.
                if (xfer && bus.in_data == MAGIC) begin
                    state_d = S_CNT_LO;
                    idx_d   = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            S_CNT_LO: begin
                if (xfer) begin
                    cnt_d   = {8'h00, bus.in_data};
                    state_d = S_CNT_HI;
                end
            end
            S_CNT_HI: begin
                if (xfer) begin
                    cnt_d = n_full;
                    if ({1'b0, n_full} > DEPTH_W) begin
                        state_d = S_ERR;
                    end else if (n_full == 16'd0) begin
                        state_d = S_AFTER_LAST;
                    end else begin
                        state_d = S_DATA;
                        addr_d  = BASE_W;
                        idx_d   = '0;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    idx_d = idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q + bus.in_data;
`endif
                    case (idx_q)
                        2'd0: asm_d[7:0]   = bus.in_data;
                        2'd1: asm_d[15:8]  = bus.in_data;
                        2'd2: asm_d[23:16] = bus.in_data;
                        default: begin
                            data_d  = {bus.in_data, asm_q};
                            state_d = S_WRITE;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                // The write itself happens this cycle; advance to the next word.
                addr_d  = addr_q + 32'd1;
                cnt_d   = cnt_q - 16'd1;
                state_d = (cnt_q == 16'd1) ? S_AFTER_LAST : S_DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) begin
                    state_d = (bus.in_data == csum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready = (state_q != S_WRITE);
    assign bus.wr_en    = (state_q == S_WRITE);
    assign bus.wr_addr  = addr_q;
    assign bus.wr_data  = data_q;
    assign cpu_rst_n    = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
    assign done         = (state_q == S_DONE);
    assign err          = (state_q == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames against imem_loader with a frame-level
// reference model checked every cycle, plus literal checks per scenario.
module tb_imem_loader;
    localparam int unsigned BASE  = 0;
    localparam int unsigned DEPTH = 128;

    logic clk = 1'b0;
    logic rst_n;
    logic cpu_rst_n, done, err;

    always #5 clk = ~clk;

    imem_loader_if bus ();

    imem_loader #(
        .BASE_WORD (BASE),
        .DEPTH     (DEPTH),
        .MAGIC     (8'hA5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .cpu_rst_n (cpu_rst_n),
        .done      (done),
        .err       (err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    bit          m_in_frame, m_done, m_err, m_wpend;
    int          m_stage;      // 1 count low, 2 count high, 3 payload, 4 checksum
    int          m_n, m_written, m_bytes;
    logic [31:0] m_word, m_exp_addr, m_exp_data;
    logic [7:0]  m_sum;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    int          ready_low_cnt = 0;

    function automatic void m_reset();
        m_in_frame = 0; m_done = 0; m_err = 0; m_wpend = 0;
        m_stage = 0; m_n = 0; m_written = 0; m_bytes = 0;
        m_word = '0; m_sum = '0;
    endfunction

    function automatic void m_finish();
`ifdef LOADER_CHECKSUM_EN
        m_stage = 4;
`else
        m_in_frame = 0;
        m_done = 1;
`endif
    endfunction

    // Per-cycle compare, then advance the model by what the next edge accepts.
    initial begin
        bit         accepted;
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_reset();
                chk("rst_in_ready",  bus.in_ready, 1);
                chk("rst_wr_en",     bus.wr_en,    0);
                chk("rst_wr_addr",   bus.wr_addr,  BASE);
                chk("rst_wr_data",   bus.wr_data,  0);
                chk("rst_cpu_rst_n", cpu_rst_n,    1);
                chk("rst_done",      done,         0);
                chk("rst_err",       err,          0);
            end else begin
                chk("in_ready",  bus.in_ready, !m_wpend);
                chk("wr_en",     bus.wr_en,    m_wpend);
                chk("cpu_rst_n", cpu_rst_n,    !m_in_frame);
                chk("done",      done,         m_done);
                chk("err",       err,          m_err);
                if (!bus.in_ready) ready_low_cnt++;
                if (bus.wr_en) begin
                    log_addr.push_back(bus.wr_addr);
                    log_data.push_back(bus.wr_data);
                end
                if (m_wpend) begin
                    chk("wr_addr", bus.wr_addr, m_exp_addr);
                    chk("wr_data", bus.wr_data, m_exp_data);
                end
                accepted = bus.in_valid && !m_wpend;
                b = bus.in_data;
                if (m_wpend) begin
                    m_wpend = 0;
                    m_written++;
                    if (m_written == m_n) m_finish();
                end
                if (accepted) begin
                    if (!m_in_frame) begin
                        if (b == 8'hA5) begin
                            m_in_frame = 1; m_done = 0; m_err = 0;
                            m_stage = 1; m_sum = '0;
                        end
                    end else begin
                        case (m_stage)
                            1: begin m_n = int'(b); m_stage = 2; end
                            2: begin
                                m_n = m_n + int'(b) * 256;
                                if (m_n > int'(DEPTH)) begin
                                    m_in_frame = 0; m_err = 1;
                                end else if (m_n == 0) begin
                                    m_finish();
                                end else begin
                                    m_stage = 3; m_written = 0; m_bytes = 0; m_word = '0;
                                end
                            end
                            3: begin
                                m_word = m_word | (32'(b) << (8 * m_bytes));
                                m_sum  = m_sum + b;
                                m_bytes++;
                                if (m_bytes == 4) begin
                                    m_wpend    = 1;
                                    m_exp_addr = 32'(BASE) + 32'(m_written);
                                    m_exp_data = m_word;
                                    m_word     = '0;
                                    m_bytes    = 0;
                                end
                            end
                            default: begin
                                m_in_frame = 0;
                                if (b == m_sum) m_done = 1; else m_err = 1;
                            end
                        endcase
                    end
                end
            end
        end
    end

    // ---------------- drivers ----------------
    // Present a byte and keep in_valid high until it is accepted.
    task automatic send(input logic [7:0] b);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        do begin
            @(negedge clk);
            guard++;
        end while (!bus.in_ready && guard < 20);
        if (!bus.in_ready) chk("send_stall", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [31:0] w[$], input bit bad_csum);
        logic [7:0] s;
        logic [7:0] b;
        logic [15:0] n;
        s = '0;
        n = 16'(w.size());
        send(8'hA5);
        send(n[7:0]);
        send(n[15:8]);
        foreach (w[i]) begin
            for (int k = 0; k < 4; k++) begin
                b = w[i][8*k +: 8];
                s = s + b;
                send(b);
            end
        end
`ifdef LOADER_CHECKSUM_EN
        send(bad_csum ? ~s : s);
`else
        if (bad_csum) s = '0;
`endif
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    initial begin
        logic [7:0]  t2[$];
        logic [31:0] w[$];
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  t2[$];
        logic [31:0] w[$];
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: reset state
        chk("t1_in_ready",  bus.in_ready, 1);
        chk("t1_cpu_rst_n", cpu_rst_n, 1);
        chk("t1_wr_en",     bus.wr_en, 0);
        chk("t1_done",      done, 0);
        chk("t1_err",       err, 0);

        // 2: two-word frame, exact bytes
        clear_log();
        t2 = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h07, 8'h00, 8'h00};
        foreach (t2[i]) send(t2[i]);
`ifdef LOADER_CHECKSUM_EN
        send(8'hD1);
`endif
        idle(3);
        chk("t2_nwrites", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            chk("t2_addr0", log_addr[0], 32'd0);
            chk("t2_data0", log_data[0], 32'h0000_0013);
            chk("t2_addr1", log_addr[1], 32'd1);
            chk("t2_data1", log_data[1], 32'h0000_07B7);
        end
        chk("t2_done", done, 1);
        chk("t2_cpu_rst_n", cpu_rst_n, 1);

        // 3: leading garbage dropped
        clear_log();
        send(8'h00); send(8'hFF); send(8'h13);
        w = '{32'hDEAD_BEEF};
        send_frame(w, 1'b0);
        idle(3);
        chk("t3_nwrites", log_addr.size(), 1);
        if (log_addr.size() == 1) begin
            chk("t3_addr", log_addr[0], 32'd0);
            chk("t3_data", log_data[0], 32'hDEAD_BEEF);
        end
        chk("t3_done", done, 1);

        // 4: count above DEPTH, then recovery
        clear_log();
        send(8'hA5); send(8'h81); send(8'h00);
        idle(2);
        chk("t4_err", err, 1);
        chk("t4_cpu_rst_n", cpu_rst_n, 1);
        chk("t4_nwrites", log_addr.size(), 0);
        w = '{32'h1234_5678};
        send_frame(w, 1'b0);
        idle(3);
        chk("t4_done", done, 1);
        chk("t4_err_clr", err, 0);

`ifdef LOADER_CHECKSUM_EN
        // 5: wrong checksum keeps the written word but flags err
        clear_log();
        w = '{32'hCAFE_F00D};
        send_frame(w, 1'b1);
        idle(3);
        chk("t5_nwrites", log_addr.size(), 1);
        chk("t5_err", err, 1);
        chk("t5_done", done, 0);
`endif

        // 6: in_valid held high through a 3-word frame
        clear_log();
        ready_low_cnt = 0;
        w = '{32'h0302_0100, 32'h0706_0504, 32'hFFEE_DDCC};
        send_frame(w, 1'b0);
        idle(3);
        chk("t6_ready_low", ready_low_cnt, 3);
        chk("t6_nwrites", log_addr.size(), 3);
        if (log_addr.size() == 3) begin
            chk("t6_data2", log_data[2], 32'hFFEE_DDCC);
            chk("t6_addr2", log_addr[2], 32'd2);
        end

        // 7: reset mid-payload
        clear_log();
        send(8'hA5); send(8'h02); send(8'h00); send(8'h11); send(8'h22);
        rst_n = 1'b0;
        #1;
        chk("t7_in_ready",  bus.in_ready, 1);
        chk("t7_wr_en",     bus.wr_en, 0);
        chk("t7_cpu_rst_n", cpu_rst_n, 1);
        chk("t7_done",      done, 0);
        chk("t7_wr_addr",   bus.wr_addr, 32'd0);
        chk("t7_wr_data",   bus.wr_data, 32'd0);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(4);
        chk("t7_nwrites", log_addr.size(), 0);
        chk("t7_done_after", done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
